// File: rtl/queue_push_arbiter_pkg.sv
// Shared types and helpers for the instruction-queue push arbiter.
// Optional performance counters are enabled in the top with QUEUE_ARB_PERF_EN.
package queue_push_arbiter_pkg;

    typedef logic [31:0] instruction_info_reg_t;

    typedef enum logic [1:0] {
        ARB_RUN,
        ARB_CLEAR,
        ARB_HOLD
    } queue_arb_state_t;

    function automatic int qarb_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int QARB_DEPTH_DEFAULT = 8;
    localparam int QARB_CNT_W         = qarb_cnt_w(QARB_DEPTH_DEFAULT);

endpackage

// File: rtl/queue_push_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
// Shared with the issue logic, so it carries no state of its own.
module queue_push_arbiter_rr_arbiter #(
    parameter  int NREQ  = 3,
    localparam int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] winner
);

    logic [PTR_W-1:0] idx;

    // Walk from the farthest offset back to ptr so the closest request is the last one written.
    always_comb begin
        gnt    = '0;
        winner = '0;
        idx    = '0;
        if (en) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx = PTR_W'((int'(ptr) + k) % NREQ);
                if (req[idx]) begin
                    gnt      = '0;
                    gnt[idx] = 1'b1;
                    winner   = idx;
                end
            end
        end
    end

endmodule

// File: rtl/queue_push_arbiter.sv
// Shares one circular queue's push port among NREQ requesters and sequences pops/flushes.
// Define QUEUE_ARB_PERF_EN to add per-requester stall counters and a full-cycle counter.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ARB_RUN   | normal operation, grants and pops allowed
//   ARB_CLEAR | q_clear asserted for one cycle, count/rr_ptr reset
//   ARB_HOLD  | waiting for flush to drop
module queue_push_arbiter
    import queue_push_arbiter_pkg::*;
#(
    parameter  type QUEUE_TYPE = instruction_info_reg_t,
    parameter  int  NREQ       = 3,
    parameter  int  PUSH_W     = 2,
    parameter  int  POP_W      = 2,
    parameter  int  DEPTH      = 8,
    localparam int  CNT_W      = qarb_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  QUEUE_TYPE        req_data [NREQ][PUSH_W],
    output logic [NREQ-1:0]  gnt,
    output logic             q_push,
    output QUEUE_TYPE        q_in [PUSH_W],
    input  logic             pop_req,
    output logic             q_pop,
    output logic             pop_valid,
    input  logic             flush,
    output logic             q_clear,
    output logic [CNT_W-1:0] count,
    output logic             busy
`ifdef QUEUE_ARB_PERF_EN
    ,
    output logic [31:0]      stall_cnt [NREQ],
    output logic [31:0]      full_cycles
`endif
);

    localparam int PTR_W = $clog2(NREQ);

    queue_arb_state_t state, state_next;
    logic [PTR_W-1:0] rr_ptr, winner;
    logic             room, run_ok, pop_ok;

    // One extra bit keeps count + PUSH_W from wrapping; a same-cycle pop is not credited.
    assign room   = ({1'b0, count} + (CNT_W+1)'(PUSH_W)) <= (CNT_W+1)'(DEPTH);
    assign run_ok = rst && (state == ARB_RUN) && !flush;
    assign pop_ok = count >= CNT_W'(POP_W);
    assign busy   = (state != ARB_RUN);

    queue_push_arbiter_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req    (req),
        .ptr    (rr_ptr),
        .en     (run_ok && room),
        .gnt    (gnt),
        .winner (winner)
    );

    assign q_push = |gnt;
    assign q_pop  = run_ok && pop_req && pop_ok;

    always_comb begin
        for (int p = 0; p < PUSH_W; p++) begin
            q_in[p] = req_data[winner][p];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_RUN:   if (flush) state_next = ARB_CLEAR;
            ARB_CLEAR: state_next = flush ? ARB_HOLD : ARB_RUN;
            ARB_HOLD:  if (!flush) state_next = ARB_RUN;
            default:   state_next = ARB_RUN;
        endcase
    end

    // q_clear is registered from the next state so it lines up exactly with ARB_CLEAR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_RUN;
            count     <= '0;
            rr_ptr    <= '0;
            pop_valid <= 1'b0;
            q_clear   <= 1'b1;
        end else begin
            state     <= state_next;
            pop_valid <= q_pop;
            q_clear   <= (state_next == ARB_CLEAR);
            if (state == ARB_CLEAR) begin
                count  <= '0;
                rr_ptr <= '0;
            end else begin
                count <= count + (q_push ? CNT_W'(PUSH_W) : '0) - (q_pop ? CNT_W'(POP_W) : '0);
                if (q_push) begin
                    rr_ptr <= (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;
                end
            end
        end
    end

`ifdef QUEUE_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                stall_cnt[i] <= '0;
            end
            full_cycles <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && !gnt[i] && (stall_cnt[i] != '1)) begin
                    stall_cnt[i] <= stall_cnt[i] + 32'd1;
                end
            end
            if ((state == ARB_RUN) && !room && (full_cycles != '1)) begin
                full_cycles <= full_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/queue_push_arbiter.md
Name: queue_push_arbiter

Overview:
- Controller that shares the push port of one circular instruction queue between NREQ requesters (e.g. decode lanes, replay path) and sequences its pops and flushes.
- Keeps a shadow occupancy count so grants never overflow the queue and pops never underflow it.
- Grants round-robin, one requester per cycle. Drives the queue's push, pop and clear controls; the queue itself stores the data.

Parameters:
- QUEUE_TYPE, instruction_info_reg_t, entry type passed through to the queue
- NREQ, 3, number of push requesters (>=2)
- PUSH_W, 2, entries written per granted push (equals the queue's IN_WIDTH)
- POP_W, 2, entries removed per pop (equals the queue's pop amount)
- DEPTH, 8, queue depth; power of two, >= max(PUSH_W, POP_W)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  requester i wants to push PUSH_W entries
- req_data  in  NREQ x PUSH_W x QUEUE_TYPE  per-requester payload
- gnt  out  NREQ  one-hot grant, combinational; payload is taken this cycle
- q_push  out  1  queue push strobe
- q_in  out  PUSH_W x QUEUE_TYPE  muxed payload of the granted requester
- pop_req  in  1  consumer wants POP_W entries
- q_pop  out  1  queue pop strobe
- pop_valid  out  1  registered; queue out[] is valid this cycle
- flush  in  1  discard all queue contents
- q_clear  out  1  registered; drives the queue's clear/reset input
- count  out  $clog2(DEPTH)+1  current occupancy
- busy  out  1  FSM is not in RUN

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, count=0, rr_ptr=0, pop_valid=0, q_clear=1 (the queue is held clear during reset). All outputs deassert when rst rises, except q_clear, which deasserts at the first clk edge after rst rises.
- FSM states:
  - RUN: normal operation.
  - CLEAR: q_clear=1 for exactly one cycle.
  - HOLD: waits for flush to drop.
- RUN transitions:
  - flush=1 → CLEAR. In that cycle gnt=0, q_push=0 and q_pop=0, regardless of req and pop_req.
- CLEAR transitions:
  - count<=0, rr_ptr<=0.
  - Next state is HOLD if flush=1, otherwise RUN.
- HOLD transitions:
  - gnt=0, q_pop=0.
  - Go to RUN on the first cycle flush=0. No grants occur in that cycle.
- room = (count + PUSH_W <= DEPTH). Computed with one extra bit so there is no wrap. A pop in the same cycle does not add room; the check is conservative.
- Grant rule:
  - In RUN, with flush=0 and room: grant the first i with req[i]=1, searching rr_ptr, rr_ptr+1, … mod NREQ.
  - gnt[i]=1, q_push=1, q_in=req_data[i].
  - rr_ptr <= (i+1) mod NREQ. rr_ptr does not change when there is no grant.
- Pop rule: in RUN, with flush=0, pop_req=1 and count >= POP_W: q_pop=1. pop_valid <= q_pop, so it has 1-cycle latency and matches the queue's registered out[].
- count update: count <= count + (q_push ? PUSH_W : 0) − (q_pop ? POP_W : 0). Push and pop in the same cycle are both applied.
- Invariants (assertable):
  - 0 <= count <= DEPTH.
  - gnt is zero or one-hot.
  - No q_push/q_pop while busy.
- A pop_valid already in flight when flush rises still asserts next cycle. The consumer must ignore it in the flush cycle.
- Requesters hold req and req_data until granted. The arbiter keeps no state per requester other than rr_ptr.

Optional Feature:
- Macro QUEUE_ARB_PERF_EN.
- When defined:
  - Adds output stall_cnt (NREQ x 32): per-requester saturating counter.
  - Increments each cycle req[i]=1 and gnt[i]=0, including busy cycles.
  - Cleared by rst only; unaffected by flush.
  - Adds output full_cycles (32): saturating count of RUN cycles with room=0.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- rv32i_types additions:
  - enum queue_arb_state_t {ARB_RUN, ARB_CLEAR, ARB_HOLD}.
  - localparam QARB_CNT_W helper function (clog2(DEPTH)+1).
- Sub-module rr_arbiter: NREQ parameter; inputs req, ptr, en; outputs one-hot gnt and winner index. Purely combinational; reusable by the issue logic.

Test Plan:
- Fairness: NREQ=3, all req=1 held, pop_req=1 always, DEPTH=8 → gnt cycles 001,010,100,001…; count never exceeds 8.
- Full: pops disabled, req[0]=1 → 4 grants; count=8; 5th cycle gnt=0, q_push=0. Enable pop_req → q_pop=1, count=6 next cycle, grant resumes the cycle after.
- Empty: count=0, pop_req=1 → q_pop=0, pop_valid=0. Count=2, pop_req=1 → q_pop=1; pop_valid=1 one cycle later; count=0.
- Simultaneous: count=4, push and pop in the same cycle → count=4 next cycle, q_push=q_pop=1.
- Flush: count=6, flush pulse of 1 cycle → that cycle gnt=0, q_pop=0; next cycle q_clear=1; following cycle state RUN, count=0, rr_ptr=0. Flush held for 3 cycles → busy stays 1 until the cycle after flush drops.
- Async reset mid-run: rst low between clock edges with count=5 → count=0, gnt=0 immediately, q_clear=1. With QUEUE_ARB_PERF_EN: stall_cnt=0 and full_cycles=0.
